// File: rtl/controlador_interrupciones.sv
// controlador_interrupciones: vectored interrupt controller sharing the sequencer's interrupt-jump path.
// Latency: irq edge -> pendientes 1 cycle; -> cc low with vect/fuente_activa valid 2 cycles; grant -> en_servicio 1 cycle.
// Backpressure: a request holds cc low until the sequencer takes the vector jump or the source gets masked.
// Ports: reloj/reset (async, active-high); irq request lines; mascara_we/mascara_dato mask write;
//        microinstruccion/vect_hab/fin_isr from sequencer and microcode;
//        cc/vect/pendientes/en_servicio/fuente_activa towards the sequencer.
// Optional macro ANIDAMIENTO_EN: nested interrupts through a stack of in-service sources.
module controlador_interrupciones #(
   parameter int         N_FUENTES = 4,
   parameter logic [3:0] BASE_VECT = 4'h8
) (
   input  logic                 reloj,
   input  logic                 reset,
   input  logic [N_FUENTES-1:0] irq,
   input  logic                 mascara_we,
   input  logic [N_FUENTES-1:0] mascara_dato,
   input  logic [1:0]           microinstruccion,
   input  logic                 vect_hab,
   input  logic                 fin_isr,
   output logic                 cc,
   output logic [3:0]           vect,
   output logic [N_FUENTES-1:0] pendientes,
   output logic                 en_servicio,
   output logic [1:0]           fuente_activa
);

   typedef enum logic [1:0] {INACTIVO = 2'd0, SOLICITUD = 2'd1, SERVICIO = 2'd2} estado_t;

   estado_t              r_estado, w_estado_sig;
   logic [N_FUENTES-1:0] r_irq_prev, r_pend, r_mask;
   logic [3:0]           r_vect;
   logic [1:0]           r_fuente;
   logic [N_FUENTES-1:0] w_elegible, w_set, w_clr;
   logic [1:0]           w_ganador;
   logic                 w_hay, w_conceder, w_cargar;

   assign w_elegible = r_pend & ~r_mask;
   assign w_set      = irq & ~r_irq_prev;
   assign w_hay      = |w_elegible;
   assign w_conceder = (r_estado == SOLICITUD) && (microinstruccion == 2'b11) && !vect_hab;

   // Fixed priority: scanning downwards leaves the lowest eligible index.
   always_comb begin
      w_ganador = 2'd0;
      for (int i = N_FUENTES - 1; i >= 0; i--)
         if (w_elegible[i]) w_ganador = 2'(i);
   end

   always_comb begin
      w_clr = '0;
      for (int i = 0; i < N_FUENTES; i++)
         w_clr[i] = w_conceder && (r_fuente == 2'(i));
   end

`ifdef ANIDAMIENTO_EN
   localparam int PW = $clog2(N_FUENTES + 1);
   localparam int IW = $clog2(N_FUENTES);

   // A source is pushed only when it strictly outranks the top, so each
   // source appears at most once and the stack never overflows.
   logic [1:0]    r_pila [N_FUENTES];
   logic [PW-1:0] r_prof, w_prof_sig, w_idx_tope;
   logic [1:0]    w_tope;
   logic          w_push;

   assign w_idx_tope = r_prof - 1'b1;
   assign w_tope     = (r_prof != '0) ? r_pila[w_idx_tope[IW-1:0]] : r_fuente;
`endif

   always_comb begin
      w_estado_sig = r_estado;
      w_cargar     = 1'b0;
`ifdef ANIDAMIENTO_EN
      w_prof_sig   = r_prof;
      w_push       = 1'b0;
`endif
      case (r_estado)
         INACTIVO: begin
            if (w_hay) begin
               w_estado_sig = SOLICITUD;
               w_cargar     = 1'b1;
            end
         end
         SOLICITUD: begin
            // The grant wins over a mask change on the requesting source.
            if (w_conceder) begin
               w_estado_sig = SERVICIO;
`ifdef ANIDAMIENTO_EN
               w_push       = 1'b1;
               w_prof_sig   = r_prof + 1'b1;
`endif
            end else begin
`ifdef ANIDAMIENTO_EN
               if (fin_isr && (r_prof != '0)) w_prof_sig = r_prof - 1'b1;
               if (r_mask[r_fuente])
                  w_estado_sig = (w_prof_sig != '0) ? SERVICIO : INACTIVO;
`else
               if (r_mask[r_fuente]) w_estado_sig = INACTIVO;
`endif
            end
         end
         SERVICIO: begin
`ifdef ANIDAMIENTO_EN
            if (fin_isr) begin
               w_prof_sig = r_prof - 1'b1;
               if (r_prof == PW'(1)) w_estado_sig = INACTIVO;
            end else if (w_hay && (w_ganador < w_tope)) begin
               w_estado_sig = SOLICITUD;
               w_cargar     = 1'b1;
            end
`else
            if (fin_isr) w_estado_sig = INACTIVO;
`endif
         end
         default: w_estado_sig = INACTIVO;
      endcase
   end

   always_ff @(posedge reloj or posedge reset) begin
      if (reset) begin
         r_estado   <= INACTIVO;
         r_irq_prev <= '0;
         r_pend     <= '0;
         r_mask     <= '1;
         r_vect     <= BASE_VECT;
         r_fuente   <= 2'd0;
      end else begin
         r_estado   <= w_estado_sig;
         r_irq_prev <= irq;
         // A new edge on the bit being cleared keeps it set.
         r_pend     <= (r_pend & ~w_clr) | w_set;
         if (mascara_we) r_mask <= mascara_dato;
         if (w_cargar) begin
            r_vect   <= BASE_VECT + {2'b00, w_ganador};
            r_fuente <= w_ganador;
         end
      end
   end

`ifdef ANIDAMIENTO_EN
   always_ff @(posedge reloj or posedge reset) begin
      if (reset) begin
         r_prof <= '0;
         for (int i = 0; i < N_FUENTES; i++) r_pila[i] <= 2'd0;
      end else begin
         r_prof <= w_prof_sig;
         if (w_push) r_pila[r_prof[IW-1:0]] <= r_fuente;
      end
   end

   assign en_servicio   = (r_prof != '0);
   assign fuente_activa = (r_estado == SOLICITUD) ? r_fuente : w_tope;
`else
   assign en_servicio   = (r_estado == SERVICIO);
   assign fuente_activa = r_fuente;
`endif

   assign cc         = (r_estado != SOLICITUD);
   assign vect       = r_vect;
   assign pendientes = r_pend;

endmodule

// File: doc/controlador_interrupciones.md
Name:
controlador_interrupciones

Overview:
- Vectored interrupt controller that shares the microprogram sequencer's interrupt-jump path among several request sources.
- Latches rising edges on the request lines and masks them per source.
- Selects one source by fixed priority and presents a 4-bit vector plus an active-low condition code for the sequencer's interrupt-jump microinstruction (2'b11).
- Tracks the in-service source until the microcode signals end of service.

Parameters:
N_FUENTES, 4, number of request sources; legal range 2..4; index 0 has the highest priority.
BASE_VECT, 4'h8, vector of source 0; source i gets vector (BASE_VECT + i) mod 16.

Ports:
reloj  input  1  system clock, all state updates on posedge.
reset  input  1  asynchronous, active-high; clears all state immediately.
irq  input  N_FUENTES  request lines; a rising edge (0 in previous cycle, 1 now) sets the pending bit.
mascara_we  input  1  mask write enable.
mascara_dato  input  N_FUENTES  new mask value; 1 = source masked.
microinstruccion  input  2  sequencer's current microinstruction field.
vect_hab  input  1  sequencer's vector-enable, active-low; low means the vector jump is being taken.
fin_isr  input  1  one-cycle pulse from microcode marking end of the service routine.
cc  output  1  condition code to sequencer, active-low; 0 = vector request outstanding.
vect  output  4  vector of the selected source, registered.
pendientes  output  N_FUENTES  pending bits, registered.
en_servicio  output  1  1 while a source is being serviced.
fuente_activa  output  2  index of the selected or in-service source.

Behaviour:
- Reset values:
  - state INACTIVO, cc=1, vect=BASE_VECT, pendientes=0, en_servicio=0, fuente_activa=0.
  - mask = all ones, so every source is masked; irq edge history = 0.
- Edge detection:
  - irq_prev is registered each cycle.
  - pend[i] is set when irq[i] & ~irq_prev[i], regardless of mask.
  - Masking only blocks selection; it never clears a pending bit.
- Eligible set: elegible = pend & ~mask. Winner = lowest set index.
- Mask write takes effect at the clock edge where mascara_we=1; the new mask is used from the next cycle.
- State INACTIVO:
  - If elegible != 0: register vect = BASE_VECT + winner and fuente_activa = winner, then go to SOLICITUD.
  - cc goes low in the first SOLICITUD cycle, one cycle after the pending edge was latched.
- State SOLICITUD:
  - cc=0; vect and fuente_activa are frozen, with no preemption by later, higher-priority arrivals.
  - If microinstruccion==2'b11 and vect_hab==0 at a clock edge: clear pend[fuente_activa], go to SERVICIO.
  - Else, if mask[fuente_activa] becomes 1: return to INACTIVO with the pending bit kept.
- State SERVICIO:
  - cc=1, en_servicio=1.
  - On fin_isr go to INACTIVO; re-arbitration happens from the next cycle.
- fin_isr outside SERVICIO is ignored.
- cc and en_servicio are decoded from registered state only, with no combinational path from inputs.
- Simultaneous events:
  - A new edge on the source whose pending bit is being cleared in the same cycle: the set wins, and the bit stays 1.
  - The grant condition takes priority over a same-cycle mask write.
- Reset asserted mid-operation: return to reset values at once; outstanding requests are lost.

Optional Feature:
Macro: ANIDAMIENTO_EN.
- Defined: nested interrupts.
  - Active sources are held in a stack of depth N_FUENTES.
  - In SERVICIO, an eligible source with index lower than the top of stack causes SOLICITUD with that source's vector.
  - A grant pushes the source onto the stack.
  - fin_isr pops the stack; the block leaves SERVICIO only when the stack is empty.
  - fin_isr in SOLICITUD pops the stack and stays in SOLICITUD.
  - en_servicio = (stack depth > 0).
  - fuente_activa shows the top of stack when not in SOLICITUD.
- Undefined: no stack; SERVICIO ignores all requests until fin_isr, as described above.

Test Plan:
- Reset, then write mask=4'b0000; pulse irq[2] -> pendientes=4'b0100 next cycle; one cycle later cc=0, vect=4'hA, fuente_activa=2.
- In SOLICITUD, drive microinstruccion=2'b11, vect_hab=0 for one cycle -> pendientes=0, en_servicio=1, cc=1. Pulse fin_isr -> en_servicio=0.
- Pulse irq[3] and irq[1] in the same cycle -> vect=4'h9 served first. After fin_isr, vect=4'hB, cc=0.
- mask=4'b0010, pulse irq[1] -> pendientes=4'b0010, cc stays 1. Write mask=0 -> cc=0, vect=4'h9 one cycle later.
- In SOLICITUD for source 0, write mask=4'b0001 -> back to INACTIVO, cc=1, pendientes bit0 still 1.
- ANIDAMIENTO_EN: serve source 3, then pulse irq[0] -> cc=0, vect=4'h8. After the grant, two fin_isr pulses are needed before en_servicio=0. Without the macro, cc stays 1 until the first fin_isr.
